axil2iob: RTL and testbench



---
 rtl/axil2iob_pkg.sv | 25 ++
 rtl/iob_reg_re.sv | 24 ++
 rtl/axil2iob.sv | 189 ++++++++++++++++++
 tb/tb_axil2iob.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil2iob_pkg.sv
// Shared encodings for the AXI4-Lite to IOb bridge: FSM states, AXI response
// codes and the read/write arbitration priority values.
package axil2iob_pkg;

  localparam int ST_W = 3;

  localparam logic [ST_W-1:0] ST_IDLE    = 3'd0;
  localparam logic [ST_W-1:0] ST_WR_REQ  = 3'd1;
  localparam logic [ST_W-1:0] ST_WR_RESP = 3'd2;
  localparam logic [ST_W-1:0] ST_RD_REQ  = 3'd3;
  localparam logic [ST_W-1:0] ST_RD_WAIT = 3'd4;
  localparam logic [ST_W-1:0] ST_RD_RESP = 3'd5;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Value of prio_q saying which channel wins the next read/write collision.
  localparam logic PRIO_RD = 1'b0;
  localparam logic PRIO_WR = 1'b1;

  function automatic logic is_req_state(input logic [ST_W-1:0] st);
    return (st == ST_WR_REQ) || (st == ST_RD_REQ);
  endfunction

endpackage

// File: rtl/iob_reg_re.sv
// Generic register with asynchronous active-high reset and load enable;
// every flop of the bridge is built from this cell.
module iob_reg_re #(
  parameter int                DATA_W  = 1,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic              clk_i,
  input  logic              arst_i,
  input  logic              en_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o
);

  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // pre-edge values, independent of process ordering.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      data_o <= RST_VAL;
    end else if (en_i) begin
      data_o <= data_i;
    end
  end

endmodule

// File: rtl/axil2iob.sv
// AXI4-Lite slave to IOb master bridge, one transaction in flight. AW/W are
// captured independently; read/write collisions alternate via prio_q.
module axil2iob
  import axil2iob_pkg::*;
#(
  parameter int AXIL_ADDR_W = 21,
  parameter int AXIL_DATA_W = 32,
  parameter int ADDR_W      = AXIL_ADDR_W,
  parameter int DATA_W      = AXIL_DATA_W
) (
  input  logic                     clk_i,
  input  logic                     arst_i,

  input  logic                     axil_awvalid_i,
  output logic                     axil_awready_o,
  input  logic [AXIL_ADDR_W-1:0]   axil_awaddr_i,
  input  logic [2:0]               axil_awprot_i,

  input  logic                     axil_wvalid_i,
  output logic                     axil_wready_o,
  input  logic [AXIL_DATA_W-1:0]   axil_wdata_i,
  input  logic [AXIL_DATA_W/8-1:0] axil_wstrb_i,

  output logic                     axil_bvalid_o,
  input  logic                     axil_bready_i,
  output logic [1:0]               axil_bresp_o,

  input  logic                     axil_arvalid_i,
  output logic                     axil_arready_o,
  input  logic [AXIL_ADDR_W-1:0]   axil_araddr_i,
  input  logic [2:0]               axil_arprot_i,

  output logic                     axil_rvalid_o,
  input  logic                     axil_rready_i,
  output logic [AXIL_DATA_W-1:0]   axil_rdata_o,
  output logic [1:0]               axil_rresp_o,

  output logic                     iob_avalid_o,
  output logic [ADDR_W-1:0]        iob_addr_o,
  output logic [DATA_W-1:0]        iob_wdata_o,
  output logic [DATA_W/8-1:0]      iob_wstrb_o,
  input  logic                     iob_ready_i,
  input  logic                     iob_rvalid_i,
  input  logic [DATA_W-1:0]        iob_rdata_i
);

  logic [ST_W-1:0]     state_q, state_d;
  logic                aw_full_q, aw_full_d;
  logic                w_full_q, w_full_d;
  logic                prio_q, prio_d;
  logic                run_q;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                addr_en;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W/8-1:0] wstrb_q, wstrb_eff;
  logic [DATA_W-1:0]   rdata_q;
  logic                rdata_en;

  logic idle, empty, wr_pending, collide, rd_wins;
  logic aw_hs, w_hs, ar_hs;
  logic unused_in;

  // Protection bits and any address bits above ADDR_W are intentionally dropped.
  assign unused_in = ^{axil_awprot_i, axil_arprot_i, axil_awaddr_i, axil_araddr_i};

  // run_q keeps every ready low while reset is held and for the release cycle.
  assign idle       = run_q && (state_q == ST_IDLE);
  assign empty      = !aw_full_q && !w_full_q;
  assign wr_pending = axil_awvalid_i || axil_wvalid_i;
  assign collide    = empty && axil_arvalid_i && wr_pending;
  assign rd_wins    = (prio_q == PRIO_RD);

  assign axil_awready_o = idle && !aw_full_q && !(collide && rd_wins);
  assign axil_wready_o  = idle && !w_full_q && !(collide && rd_wins);
  assign axil_arready_o = idle && empty && (!wr_pending || rd_wins);

  assign aw_hs = axil_awvalid_i && axil_awready_o;
  assign w_hs  = axil_wvalid_i && axil_wready_o;
  assign ar_hs = axil_arvalid_i && axil_arready_o;

  assign wstrb_eff = w_hs ? axil_wstrb_i : wstrb_q;

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    aw_full_d = aw_full_q || aw_hs;
    w_full_d  = w_full_q || w_hs;
    prio_d    = prio_q;
    addr_en   = aw_hs || ar_hs;
    addr_d    = ar_hs ? axil_araddr_i[ADDR_W-1:0] : axil_awaddr_i[ADDR_W-1:0];
    rdata_en  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (ar_hs) begin
          state_d = ST_RD_REQ;
        end else if (aw_full_d && w_full_d) begin
          // An all-zero strobe would look like a read on IOb, so answer directly.
          if (wstrb_eff == '0) begin
            state_d   = ST_WR_RESP;
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
          end else begin
            state_d = ST_WR_REQ;
          end
        end
      end
      ST_WR_REQ: begin
        if (iob_ready_i) begin
          state_d   = ST_WR_RESP;
          aw_full_d = 1'b0;
          w_full_d  = 1'b0;
        end
      end
      ST_WR_RESP: begin
        if (axil_bready_i) begin
          state_d = ST_IDLE;
          prio_d  = !prio_q;
        end
      end
      ST_RD_REQ: begin
        if (iob_ready_i) state_d = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (iob_rvalid_i) begin
          rdata_en = 1'b1;
          state_d  = ST_RD_RESP;
        end
      end
      ST_RD_RESP: begin
        if (axil_rready_i) begin
          state_d = ST_IDLE;
          prio_d  = !prio_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  iob_reg_re #(.DATA_W(ST_W), .RST_VAL(ST_IDLE)) u_state_reg (
    .clk_i(clk_i), .arst_i(arst_i), .en_i(1'b1), .data_i(state_d), .data_o(state_q)
  );

  iob_reg_re #(.DATA_W(1), .RST_VAL(1'b0)) u_aw_full_reg (
    .clk_i(clk_i), .arst_i(arst_i), .en_i(1'b1), .data_i(aw_full_d), .data_o(aw_full_q)
  );

  iob_reg_re #(.DATA_W(1), .RST_VAL(1'b0)) u_w_full_reg (
    .clk_i(clk_i), .arst_i(arst_i), .en_i(1'b1), .data_i(w_full_d), .data_o(w_full_q)
  );

  iob_reg_re #(.DATA_W(1), .RST_VAL(PRIO_RD)) u_prio_reg (
    .clk_i(clk_i), .arst_i(arst_i), .en_i(1'b1), .data_i(prio_d), .data_o(prio_q)
  );

  iob_reg_re #(.DATA_W(1), .RST_VAL(1'b0)) u_run_reg (
    .clk_i(clk_i), .arst_i(arst_i), .en_i(1'b1), .data_i(1'b1), .data_o(run_q)
  );

  // One address register serves both directions; only one transaction is live.
  iob_reg_re #(.DATA_W(ADDR_W), .RST_VAL('0)) u_addr_reg (
    .clk_i(clk_i), .arst_i(arst_i), .en_i(addr_en), .data_i(addr_d), .data_o(addr_q)
  );

  iob_reg_re #(.DATA_W(DATA_W), .RST_VAL('0)) u_wdata_reg (
    .clk_i(clk_i), .arst_i(arst_i), .en_i(w_hs), .data_i(axil_wdata_i), .data_o(wdata_q)
  );

  iob_reg_re #(.DATA_W(DATA_W/8), .RST_VAL('0)) u_wstrb_reg (
    .clk_i(clk_i), .arst_i(arst_i), .en_i(w_hs), .data_i(axil_wstrb_i), .data_o(wstrb_q)
  );

  iob_reg_re #(.DATA_W(DATA_W), .RST_VAL('0)) u_rdata_reg (
    .clk_i(clk_i), .arst_i(arst_i), .en_i(rdata_en), .data_i(iob_rdata_i), .data_o(rdata_q)
  );

  assign iob_avalid_o = is_req_state(state_q);
  assign iob_addr_o   = addr_q;
  assign iob_wdata_o  = wdata_q;
  assign iob_wstrb_o  = (state_q == ST_WR_REQ) ? wstrb_q : '0;

  assign axil_bvalid_o = (state_q == ST_WR_RESP);
  assign axil_bresp_o  = RESP_OKAY;
  assign axil_rvalid_o = (state_q == ST_RD_RESP);
  assign axil_rdata_o  = rdata_q;
  assign axil_rresp_o  = RESP_OKAY;

endmodule

// File: tb/tb_axil2iob.sv
// Directed bench for axil2iob: a table of single transactions with exact
// latency checks, plus hand sequences for ordering, stalls, arbitration, reset.
module tb_axil2iob;

  localparam int AW = 21;
  localparam int DW = 32;

  logic clk_i  = 1'b0;
  logic arst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  logic          axil_awvalid_i = 0, axil_awready_o;
  logic [AW-1:0] axil_awaddr_i  = '0;
  logic [2:0]    axil_awprot_i  = '0;
  logic          axil_wvalid_i  = 0, axil_wready_o;
  logic [DW-1:0] axil_wdata_i   = '0;
  logic [3:0]    axil_wstrb_i   = '0;
  logic          axil_bvalid_o, axil_bready_i = 0;
  logic [1:0]    axil_bresp_o;
  logic          axil_arvalid_i = 0, axil_arready_o;
  logic [AW-1:0] axil_araddr_i  = '0;
  logic [2:0]    axil_arprot_i  = '0;
  logic          axil_rvalid_o, axil_rready_i = 0;
  logic [DW-1:0] axil_rdata_o;
  logic [1:0]    axil_rresp_o;
  logic          iob_avalid_o;
  logic [AW-1:0] iob_addr_o;
  logic [DW-1:0] iob_wdata_o;
  logic [3:0]    iob_wstrb_o;
  logic          iob_ready_i  = 0;
  logic          iob_rvalid_i = 0;
  logic [DW-1:0] iob_rdata_i  = '0;

  axil2iob dut (
    .clk_i(clk_i), .arst_i(arst_i),
    .axil_awvalid_i(axil_awvalid_i), .axil_awready_o(axil_awready_o),
    .axil_awaddr_i(axil_awaddr_i), .axil_awprot_i(axil_awprot_i),
    .axil_wvalid_i(axil_wvalid_i), .axil_wready_o(axil_wready_o),
    .axil_wdata_i(axil_wdata_i), .axil_wstrb_i(axil_wstrb_i),
    .axil_bvalid_o(axil_bvalid_o), .axil_bready_i(axil_bready_i),
    .axil_bresp_o(axil_bresp_o),
    .axil_arvalid_i(axil_arvalid_i), .axil_arready_o(axil_arready_o),
    .axil_araddr_i(axil_araddr_i), .axil_arprot_i(axil_arprot_i),
    .axil_rvalid_o(axil_rvalid_o), .axil_rready_i(axil_rready_i),
    .axil_rdata_o(axil_rdata_o), .axil_rresp_o(axil_rresp_o),
    .iob_avalid_o(iob_avalid_o), .iob_addr_o(iob_addr_o),
    .iob_wdata_o(iob_wdata_o), .iob_wstrb_o(iob_wstrb_o),
    .iob_ready_i(iob_ready_i), .iob_rvalid_i(iob_rvalid_i),
    .iob_rdata_i(iob_rdata_i)
  );

  typedef struct {
    logic          rd;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [3:0]    wstrb;
    logic [DW-1:0] rdata;
    logic          exp_req;
  } vec_t;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    axil_awvalid_i = 0; axil_wvalid_i = 0; axil_arvalid_i = 0;
    axil_bready_i  = 0; axil_rready_i = 0;
    iob_ready_i    = 0; iob_rvalid_i  = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, 64'({axil_awready_o, axil_wready_o, axil_arready_o, iob_avalid_o,
                              axil_bvalid_o, axil_rvalid_o, axil_bresp_o, axil_rresp_o}), 64'd0);
    check({tag, "_addr_strb"}, 64'({iob_addr_o, iob_wstrb_o}), 64'd0);
    check({tag, "_wdata"}, 64'(iob_wdata_o), 64'd0);
    check({tag, "_rdata"}, 64'(axil_rdata_o), 64'd0);
  endtask

  task automatic do_reset();
    idle_inputs();
    arst_i = 1;
    settle();
    check_all_zero("reset");
    tick();
    tick();
    arst_i = 0;
    tick();
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    string p;
    p = $sformatf("v%0d", idx);
    if (!v.rd) begin
      axil_awvalid_i = 1; axil_awaddr_i = v.addr;
      axil_wvalid_i  = 1; axil_wdata_i  = v.wdata; axil_wstrb_i = v.wstrb;
      iob_ready_i    = 1;
      settle();
      check({p, "_aw_w_ready"}, 64'({axil_awready_o, axil_wready_o}), 64'h3);
      tick();
      axil_awvalid_i = 0; axil_wvalid_i = 0;
      axil_awaddr_i = '0; axil_wdata_i = '0; axil_wstrb_i = '0;
      check({p, "_c1_avalid"}, 64'(iob_avalid_o), 64'(v.exp_req));
      check({p, "_c1_bvalid"}, 64'(axil_bvalid_o), 64'(!v.exp_req));
      if (v.exp_req)
        check({p, "_c1_req"}, {iob_addr_o, iob_wdata_o, iob_wstrb_o, 7'd0},
              {v.addr, v.wdata, v.wstrb, 7'd0});
      tick();
      check({p, "_c2_avalid"}, 64'(iob_avalid_o), 64'd0);
      check({p, "_c2_b"}, 64'({axil_bvalid_o, axil_bresp_o}), 64'h4);
      axil_bready_i = 1;
      tick();
      axil_bready_i = 0; iob_ready_i = 0;
      check({p, "_b_done"}, 64'(axil_bvalid_o), 64'd0);
    end else begin
      axil_arvalid_i = 1; axil_araddr_i = v.addr;
      iob_ready_i    = 1;
      settle();
      check({p, "_arready"}, 64'(axil_arready_o), 64'd1);
      tick();
      axil_arvalid_i = 0; axil_araddr_i = '0;
      check({p, "_c1_req"}, 64'({iob_avalid_o, iob_wstrb_o, iob_addr_o}), 64'({1'b1, 4'h0, v.addr}));
      tick();
      iob_ready_i = 0;
      check({p, "_c2_wait"}, 64'({iob_avalid_o, axil_rvalid_o}), 64'd0);
      iob_rvalid_i = 1; iob_rdata_i = v.rdata;
      tick();
      iob_rvalid_i = 0; iob_rdata_i = ~v.rdata;
      check({p, "_c3_r"}, {axil_rvalid_o, axil_rresp_o, axil_rdata_o, 29'd0},
            {1'b1, 2'b00, v.rdata, 29'd0});
      axil_rready_i = 1;
      tick();
      axil_rready_i = 0;
      check({p, "_r_done"}, 64'(axil_rvalid_o), 64'd0);
    end
  endtask

  vec_t vecs[7];
  vec_t v_after_rst;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int avalid_cnt;

    vecs[0] = '{rd: 0, addr: 21'h00010,  wdata: 32'hDEADBEEF, wstrb: 4'hF, rdata: 32'h0,        exp_req: 1};
    vecs[1] = '{rd: 0, addr: 21'h1FFFFC, wdata: 32'h000000A5, wstrb: 4'h1, rdata: 32'h0,        exp_req: 1};
    vecs[2] = '{rd: 0, addr: 21'h00004,  wdata: 32'hFFFFFFFF, wstrb: 4'h0, rdata: 32'h0,        exp_req: 0};
    vecs[3] = '{rd: 1, addr: 21'h00100,  wdata: 32'h0,        wstrb: 4'h0, rdata: 32'hA5A55A5A, exp_req: 1};
    vecs[4] = '{rd: 1, addr: 21'h1FFFFF, wdata: 32'h0,        wstrb: 4'h0, rdata: 32'h80000001, exp_req: 1};
    vecs[5] = '{rd: 0, addr: 21'h00008,  wdata: 32'h01234567, wstrb: 4'hC, rdata: 32'h0,        exp_req: 1};
    vecs[6] = '{rd: 1, addr: 21'h00000,  wdata: 32'h0,        wstrb: 4'h0, rdata: 32'hFFFFFFFF, exp_req: 1};
    v_after_rst = '{rd: 1, addr: 21'h00044, wdata: 32'h0, wstrb: 4'h0, rdata: 32'hCAFEF00D, exp_req: 1};

    do_reset();
    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // W three cycles before AW: wready drops, one request after the AW handshake.
    axil_wvalid_i = 1; axil_wdata_i = 32'h55AA00FF; axil_wstrb_i = 4'h3;
    settle();
    check("early_w_ready", 64'(axil_wready_o), 64'd1);
    tick();
    axil_wvalid_i = 1; axil_wdata_i = 32'h0; axil_wstrb_i = 4'h0;
    avalid_cnt = 0;
    for (int c = 1; c < 3; c++) begin
      settle();
      check($sformatf("early_w_c%0d_wready", c), 64'(axil_wready_o), 64'd0);
      if (iob_avalid_o) avalid_cnt++;
      tick();
    end
    axil_wvalid_i = 0;
    axil_awvalid_i = 1; axil_awaddr_i = 21'h00020; iob_ready_i = 1;
    settle();
    check("late_aw_ready", 64'(axil_awready_o), 64'd1);
    tick();
    axil_awvalid_i = 0;
    check("late_aw_req", {iob_avalid_o, iob_addr_o, iob_wdata_o, iob_wstrb_o, 6'd0},
          {1'b1, 21'h00020, 32'h55AA00FF, 4'h3, 6'd0});
    if (iob_avalid_o) avalid_cnt++;
    tick();
    if (iob_avalid_o) avalid_cnt++;
    check("late_aw_one_req", 64'(avalid_cnt), 64'd1);
    check("late_aw_bvalid", 64'(axil_bvalid_o), 64'd1);
    axil_bready_i = 1;
    tick();
    idle_inputs();

    // Read with IOb ready held off two cycles and R held off three cycles.
    axil_arvalid_i = 1; axil_araddr_i = 21'h00030;
    tick();
    axil_arvalid_i = 0;
    for (int c = 1; c <= 3; c++) begin
      check($sformatf("slow_rd_c%0d_req", c), 64'({iob_avalid_o, iob_wstrb_o, iob_addr_o}),
            64'({1'b1, 4'h0, 21'h00030}));
      if (c == 3) iob_ready_i = 1;
      tick();
    end
    iob_ready_i = 0;
    check("slow_rd_wait", 64'(iob_avalid_o), 64'd0);
    iob_rvalid_i = 1; iob_rdata_i = 32'h12345678;
    tick();
    iob_rvalid_i = 0; iob_rdata_i = 32'h0;
    for (int c = 0; c < 3; c++) begin
      check($sformatf("slow_rd_hold%0d", c), {axil_rvalid_o, axil_rresp_o, axil_rdata_o, 29'd0},
            {1'b1, 2'b00, 32'h12345678, 29'd0});
      tick();
    end
    axil_rready_i = 1;
    tick();
    axil_rready_i = 0;
    check("slow_rd_done", 64'(axil_rvalid_o), 64'd0);

    // Collision from reset: read first, then write, then read wins again.
    do_reset();
    axil_arvalid_i = 1; axil_araddr_i = 21'h00060;
    axil_awvalid_i = 1; axil_awaddr_i = 21'h00070;
    axil_wvalid_i  = 1; axil_wdata_i  = 32'h0BADF00D; axil_wstrb_i = 4'hF;
    settle();
    check("col1_ready", 64'({axil_arready_o, axil_awready_o, axil_wready_o}), 64'b100);
    tick();
    axil_arvalid_i = 0; iob_ready_i = 1;
    check("col1_rd_addr", 64'({iob_avalid_o, iob_addr_o}), 64'({1'b1, 21'h00060}));
    tick();
    iob_ready_i = 0; iob_rvalid_i = 1; iob_rdata_i = 32'h00000111;
    tick();
    iob_rvalid_i = 0; axil_rready_i = 1;
    tick();
    axil_rready_i = 0;
    axil_arvalid_i = 1; axil_araddr_i = 21'h00080;
    settle();
    check("col2_ready", 64'({axil_arready_o, axil_awready_o, axil_wready_o}), 64'b011);
    tick();
    axil_awvalid_i = 0; axil_wvalid_i = 0; iob_ready_i = 1;
    check("col2_wr_req", 64'({iob_avalid_o, iob_addr_o, iob_wstrb_o}), 64'({1'b1, 21'h00070, 4'hF}));
    tick();
    iob_ready_i = 0; axil_bready_i = 1;
    tick();
    axil_bready_i = 0;
    axil_awvalid_i = 1; axil_wvalid_i = 1;
    settle();
    check("col3_ready", 64'({axil_arready_o, axil_awready_o, axil_wready_o}), 64'b100);
    tick();
    axil_arvalid_i = 0;
    check("col3_rd_addr", 64'({iob_avalid_o, iob_addr_o}), 64'({1'b1, 21'h00080}));

    // Reset asserted in RD_WAIT aborts the read; a fresh read then completes.
    do_reset();
    axil_arvalid_i = 1; axil_araddr_i = 21'h00050;
    tick();
    axil_arvalid_i = 0; iob_ready_i = 1;
    tick();
    iob_ready_i = 0;
    check("rst_pre_addr", 64'(iob_addr_o), 64'h50);
    arst_i = 1;
    settle();
    check_all_zero("rst_rd_wait");
    iob_rvalid_i = 1; iob_rdata_i = 32'hFFFF0000;
    tick();
    iob_rvalid_i = 0;
    arst_i = 0;
    tick();
    check("rst_no_resp", 64'({axil_rvalid_o, axil_bvalid_o, iob_avalid_o, axil_rdata_o}), 64'd0);
    run_vec(99, v_after_rst);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
